// File: rtl/regfile_sb.sv
// Parametrised register file (R0 = 0) with per-register busy scoreboard and sticky address-error flag.
// Reads are combinational with optional same-cycle write forwarding; writes, busy and addr_err update at the clock edge.
module regfile_sb #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 6,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic [DATA_W-1:0] r1,
    output logic [DATA_W-1:0] r2,
    output logic              r1_busy,
    output logic              r2_busy,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_rd,
    output logic              addr_err
);

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_X);
    endfunction

    function automatic logic is_valid(input logic [ADDR_W-1:0] a);
        return (a != '0) && in_range(a);
    endfunction

    logic [DATA_W-1:0] regs_q [1:DEPTH-1];
    logic [DATA_W-1:0] regs_d [1:DEPTH-1];
    logic [DEPTH-1:1]  busy_q;
    logic [DEPTH-1:1]  busy_d;
    logic              addr_err_q;
    logic              addr_err_d;

    logic              wr_hit;
    logic              rsv_hit;
    logic [DATA_W-1:0] r1_raw;
    logic [DATA_W-1:0] r2_raw;
    logic              b1_raw;
    logic              b2_raw;
    logic              fwd1;
    logic              fwd2;
    logic              keep1;
    logic              keep2;

    assign wr_hit  = RegWrite && is_valid(rd);
    assign rsv_hit = rsv_en && is_valid(rsv_rd);

    // A reserve on the same edge as a write keeps the register busy.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 1; i < DEPTH; i++) begin
            if (wr_hit && rd == ADDR_W'(i)) begin
                regs_d[i] = wdata;
            end
            if (rsv_hit && rsv_rd == ADDR_W'(i)) begin
                busy_d[i] = 1'b1;
            end else if (wr_hit && rd == ADDR_W'(i)) begin
                busy_d[i] = 1'b0;
            end
        end
        addr_err_d = addr_err_q
                   | (RegWrite && !in_range(rd))
                   | (rsv_en && !in_range(rsv_rd));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            addr_err_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Null addresses (R0, out of range) match no entry and read as zero / not busy.
    always_comb begin
        r1_raw = '0;
        r2_raw = '0;
        b1_raw = 1'b0;
        b2_raw = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            if (rs1 == ADDR_W'(i)) begin
                r1_raw = regs_q[i];
                b1_raw = busy_q[i];
            end
            if (rs2 == ADDR_W'(i)) begin
                r2_raw = regs_q[i];
                b2_raw = busy_q[i];
            end
        end
    end

    assign fwd1  = BYPASS && wr_hit && (rd == rs1);
    assign fwd2  = BYPASS && wr_hit && (rd == rs2);
    assign keep1 = rsv_hit && (rsv_rd == rs1);
    assign keep2 = rsv_hit && (rsv_rd == rs2);

    assign r1       = fwd1 ? wdata : r1_raw;
    assign r2       = fwd2 ? wdata : r2_raw;
    assign r1_busy  = b1_raw && !(fwd1 && !keep1);
    assign r2_busy  = b2_raw && !(fwd2 && !keep2);
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: bypass and non-bypass builds side by side, directed cases then random traffic.
module tb_regfile_sb;

    localparam int DATA_W = 24;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] rs1, rs2, rd, rsv_rd;
    logic [DATA_W-1:0] wdata;
    logic              RegWrite, rsv_en;

    logic [DATA_W-1:0] a_r1, a_r2, b_r1, b_r2;
    logic              a_r1_busy, a_r2_busy, b_r1_busy, b_r2_busy;
    logic              a_err, b_err;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .r1(a_r1), .r2(a_r2),
        .r1_busy(a_r1_busy), .r2_busy(a_r2_busy), .RegWrite(RegWrite), .rd(rd),
        .wdata(wdata), .rsv_en(rsv_en), .rsv_rd(rsv_rd), .addr_err(a_err)
    );

    regfile_sb #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYPASS(1'b0)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .r1(b_r1), .r2(b_r2),
        .r1_busy(b_r1_busy), .r2_busy(b_r2_busy), .RegWrite(RegWrite), .rd(rd),
        .wdata(wdata), .rsv_en(rsv_en), .rsv_rd(rsv_rd), .addr_err(b_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference state: plain arrays indexed by register number.
    logic [DATA_W-1:0] m_reg  [DEPTH];
    bit                m_busy [DEPTH];
    bit                m_err;

    // Current stimulus, kept as integers for the model.
    bit c_rn, c_we, c_rv;
    int c_wa, c_ra, c_a1, c_a2;
    logic [DATA_W-1:0] c_wd;

    function automatic bit valid_a(input int a);
        return (a > 0) && (a < DEPTH);
    endfunction

    function automatic logic [DATA_W-1:0] exp_r(input int a, input bit byp);
        if (!valid_a(a)) return '0;
        if (byp && c_we && c_wa == a) return c_wd;
        return m_reg[a];
    endfunction

    function automatic bit exp_busy(input int a, input bit byp);
        if (!valid_a(a)) return 1'b0;
        if (byp && c_we && c_wa == a && !(c_rv && c_ra == a)) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    // Drive one cycle's inputs and compare every output with the model before the edge.
    task automatic apply(input bit rn, input bit we, input int wa, input logic [DATA_W-1:0] wd,
                         input bit rv, input int ra, input int a1, input int a2);
        c_rn = rn; c_we = we; c_wa = wa; c_wd = wd; c_rv = rv; c_ra = ra; c_a1 = a1; c_a2 = a2;
        rst_n    = rn;
        RegWrite = we;
        rd       = ADDR_W'(wa);
        wdata    = wd;
        rsv_en   = rv;
        rsv_rd   = ADDR_W'(ra);
        rs1      = ADDR_W'(a1);
        rs2      = ADDR_W'(a2);
        #2;
        chk("byp_r1",      32'(a_r1),      32'(exp_r(a1, 1'b1)));
        chk("byp_r2",      32'(a_r2),      32'(exp_r(a2, 1'b1)));
        chk("byp_r1_busy", 32'(a_r1_busy), 32'(exp_busy(a1, 1'b1)));
        chk("byp_r2_busy", 32'(a_r2_busy), 32'(exp_busy(a2, 1'b1)));
        chk("byp_err",     32'(a_err),     32'(m_err));
        chk("nob_r1",      32'(b_r1),      32'(exp_r(a1, 1'b0)));
        chk("nob_r2",      32'(b_r2),      32'(exp_r(a2, 1'b0)));
        chk("nob_r1_busy", 32'(b_r1_busy), 32'(exp_busy(a1, 1'b0)));
        chk("nob_r2_busy", 32'(b_r2_busy), 32'(exp_busy(a2, 1'b0)));
        chk("nob_err",     32'(b_err),     32'(m_err));
    endtask

    task automatic advance();
        @(posedge clk);
        if (!c_rn) begin
            model_clear();
        end else begin
            if (c_we && valid_a(c_wa)) m_reg[c_wa] = c_wd;
            if (c_rv && valid_a(c_ra)) m_busy[c_ra] = 1'b1;
            if (c_we && valid_a(c_wa) && !(c_rv && c_ra == c_wa)) m_busy[c_wa] = 1'b0;
            if ((c_we && c_wa >= DEPTH) || (c_rv && c_ra >= DEPTH)) m_err = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input int a1, input int a2);
        apply(1'b1, 1'b0, 0, '0, 1'b0, 0, a1, a2);
    endtask

    initial begin
        rst_n = 1'b0; RegWrite = 1'b0; rsv_en = 1'b0;
        rd = '0; rsv_rd = '0; wdata = '0; rs1 = '0; rs2 = '0;
        model_clear();
        @(posedge clk);
        #1;

        // Reset clears state and overrides a same-cycle write.
        apply(1'b1, 1'b1, 3, 24'hABCDEF, 1'b1, 3, 3, 3);
        advance();
        apply(1'b0, 1'b1, 3, 24'h111111, 1'b0, 0, 3, 3);
        advance();
        idle(3, 3);
        chk("rst_r1",   32'(a_r1), 32'h0);
        chk("rst_busy", 32'(a_r1_busy), 32'h0);
        chk("rst_err",  32'(a_err), 32'h0);
        advance();

        // R0 ignores write and reserve, and is not an address error.
        apply(1'b1, 1'b1, 0, 24'hFFFFFF, 1'b1, 0, 0, 0);
        advance();
        idle(0, 0);
        chk("r0_val",  32'(a_r1), 32'h0);
        chk("r0_busy", 32'(a_r1_busy), 32'h0);
        chk("r0_err",  32'(a_err), 32'h0);
        advance();

        // Forwarding: visible before the edge only in the bypass build.
        apply(1'b1, 1'b1, 5, 24'h123456, 1'b0, 0, 5, 5);
        chk("fwd_byp", 32'(a_r1), 32'h123456);
        chk("fwd_nob", 32'(b_r1), 32'h0);
        advance();
        idle(5, 5);
        chk("fwd_nob_next", 32'(b_r1), 32'h123456);
        advance();

        // Reserve R4, hold, then writeback clears busy.
        apply(1'b1, 1'b0, 0, '0, 1'b1, 4, 0, 4);
        advance();
        idle(0, 4);
        chk("sb_busy", 32'(a_r2_busy), 32'h1);
        advance();
        idle(0, 4); advance();
        idle(0, 4); advance();
        apply(1'b1, 1'b1, 4, 24'h00000A, 1'b0, 0, 0, 4);
        advance();
        idle(0, 4);
        chk("sb_clear", 32'(b_r2_busy), 32'h0);
        chk("sb_data",  32'(b_r2), 32'h00000A);
        advance();

        // Write and reserve of R6 on the same edge.
        apply(1'b1, 1'b1, 6, 24'h000111, 1'b1, 6, 6, 6);
        advance();
        idle(6, 6);
        chk("col_data", 32'(b_r1), 32'h000111);
        chk("col_busy", 32'(b_r1_busy), 32'h1);
        advance();

        // Out-of-range write: no register change, sticky error; out-of-range read is null.
        apply(1'b1, 1'b1, 9, 24'h777777, 1'b0, 0, 12, 1);
        chk("oor_r1",   32'(a_r1), 32'h0);
        chk("oor_busy", 32'(a_r1_busy), 32'h0);
        advance();
        idle(12, 1);
        chk("oor_err", 32'(a_err), 32'h1);
        advance();
        idle(1, 2);
        chk("oor_sticky", 32'(b_err), 32'h1);
        advance();

        // Random traffic; occasional resets keep the sticky flag exercised both ways.
        for (int n = 0; n < 500; n++) begin
            bit rn, we, rv;
            int wa, ra, a1, a2;
            rn = ($urandom_range(0, 29) != 0);
            we = ($urandom_range(0, 2) != 0);
            rv = ($urandom_range(0, 3) == 0);
            wa = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, DEPTH - 1));
            ra = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, DEPTH - 1));
            a1 = ($urandom_range(0, 1) == 0) ? wa : int'($urandom_range(0, 9));
            a2 = ($urandom_range(0, 1) == 0) ? ra : int'($urandom_range(0, 9));
            apply(rn, we, wa, DATA_W'($urandom), rv, ra, a1, a2);
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
